// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART transmitter (and the receiver that will reuse them).
// Holds the FSM state encoding, the parity mode constants and the bit-period helper.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_t;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_EVEN = 1;
  localparam int PARITY_ODD  = 2;

  // System clocks per serial bit, truncating.
  function automatic int clks_per_bit(input int clk_rate, input int baud_rate);
    return clk_rate / baud_rate;
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 while enabled and pulses bit_tick on the last count.
// A clear restarts the period so each bit is timed from its own boundary, with no drift.
module uart_baud_gen #(
  parameter int CLKS_PER_BIT = 10
) (
  input  logic clock,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic bit_tick
);

  localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;

  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;

  always_comb begin
    bit_tick = enable && (count_q == CW'(CLKS_PER_BIT - 1));
    count_d  = count_q;
    if (clear || bit_tick) begin
      count_d = '0;
    end else if (enable) begin
      count_d = count_q + CW'(1);
    end
  end

  // NOTE: state registers use non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: start bit, DATA_BITS data bits LSB first, optional parity, STOP_BITS stop bits.
// All outputs are registered; the line falls on the same edge that accepts tx_start.
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLK_RATE  = 100000000,
  parameter int BAUD_RATE = 9600,
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic                 clock,
  input  logic                 rst,
  input  logic                 tx_start,
  input  logic [DATA_BITS-1:0] tx_data,
  output logic                 tx_serial,
  output logic                 tx_busy,
  output logic                 tx_done
);

  localparam int CLKS_PER_BIT = clks_per_bit(CLK_RATE, BAUD_RATE);
  localparam int IDX_W        = $clog2(DATA_BITS);
  localparam logic [IDX_W-1:0] LAST_DATA = IDX_W'(DATA_BITS - 1);
  localparam logic [IDX_W-1:0] LAST_STOP = IDX_W'(STOP_BITS - 1);
  localparam logic ODD_FLIP = (PARITY == PARITY_ODD);

  if (CLKS_PER_BIT < 2) begin : g_bad_baud
    $error("uart_tx: CLKS_PER_BIT must be at least 2");
  end
  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
    $error("uart_tx: DATA_BITS must be in 5..9");
  end
  if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
    $error("uart_tx: PARITY must be 0, 1 or 2");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
    $error("uart_tx: STOP_BITS must be 1 or 2");
  end

  tx_state_t            state_q,  state_d;
  logic [DATA_BITS-1:0] shift_q,  shift_d;
  logic [IDX_W-1:0]     idx_q,    idx_d;
  logic                 parity_q, parity_d;
  logic                 serial_q, serial_d;
  logic                 busy_q,   busy_d;
  logic                 done_q,   done_d;
  logic                 accept;
  logic                 bit_tick;

  assign accept = (state_q == IDLE) && tx_start;

  uart_baud_gen #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud_gen (
    .clock   (clock),
    .rst     (rst),
    .clear   (accept),
    .enable  (busy_q),
    .bit_tick(bit_tick)
  );

  // idx_q counts data bits in DATA and stop bits in STOP.
  always_comb begin
    // NOTE: every _d starts from its held value, so no branch can infer a latch.
    state_d  = state_q;
    shift_d  = shift_q;
    idx_d    = idx_q;
    parity_d = parity_q;
    serial_d = serial_q;
    busy_d   = busy_q;
    done_d   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (tx_start) begin
          shift_d  = tx_data;
          parity_d = (^tx_data) ^ ODD_FLIP;
          idx_d    = '0;
          serial_d = 1'b0;
          busy_d   = 1'b1;
          state_d  = START;
        end
      end
      START: begin
        if (bit_tick) begin
          serial_d = shift_q[0];
          shift_d  = shift_q >> 1;
          state_d  = DATA;
        end
      end
      DATA: begin
        if (bit_tick) begin
          if (idx_q == LAST_DATA) begin
            idx_d = '0;
            if (PARITY != PARITY_NONE) begin
              serial_d = parity_q;
              state_d  = uart_pkg::PARITY;
            end else begin
              serial_d = 1'b1;
              state_d  = STOP;
            end
          end else begin
            idx_d    = idx_q + IDX_W'(1);
            serial_d = shift_q[0];
            shift_d  = shift_q >> 1;
          end
        end
      end
      uart_pkg::PARITY: begin
        if (bit_tick) begin
          serial_d = 1'b1;
          state_d  = STOP;
        end
      end
      STOP: begin
        if (bit_tick) begin
          if (idx_q == LAST_STOP) begin
            idx_d   = '0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      default: begin
        serial_d = 1'b1;
        busy_d   = 1'b0;
        state_d  = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      shift_q  <= '0;
      idx_q    <= '0;
      parity_q <= 1'b0;
      serial_q <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      shift_q  <= shift_d;
      idx_q    <= idx_d;
      parity_q <= parity_d;
      serial_q <= serial_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign tx_serial = serial_q;
  assign tx_busy   = busy_q;
  assign tx_done   = done_q;

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx at CLKS_PER_BIT=10: four instances cover 8N1, 8E1, 8O1 and 8N2.
// Each scenario task drives its stimulus and compares the line cycle by cycle against a frame model.
module tb_uart_tx;

  localparam int CPB = 10;

  logic       clock = 1'b0;
  logic       rst;
  logic [3:0] tx_start_v;
  logic [7:0] tx_data;
  logic [3:0] serial_v;
  logic [3:0] busy_v;
  logic [3:0] done_v;

  int errors = 0;
  int checks = 0;

  always #5 clock = ~clock;

  // Instance 0: 8N1, 1: 8E1, 2: 8O1, 3: 8N2.
  uart_tx #(.CLK_RATE(1000), .BAUD_RATE(100), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) dut_n1 (
    .clock(clock), .rst(rst), .tx_start(tx_start_v[0]), .tx_data(tx_data),
    .tx_serial(serial_v[0]), .tx_busy(busy_v[0]), .tx_done(done_v[0]));
  uart_tx #(.CLK_RATE(1000), .BAUD_RATE(100), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1)) dut_e1 (
    .clock(clock), .rst(rst), .tx_start(tx_start_v[1]), .tx_data(tx_data),
    .tx_serial(serial_v[1]), .tx_busy(busy_v[1]), .tx_done(done_v[1]));
  uart_tx #(.CLK_RATE(1000), .BAUD_RATE(100), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) dut_o1 (
    .clock(clock), .rst(rst), .tx_start(tx_start_v[2]), .tx_data(tx_data),
    .tx_serial(serial_v[2]), .tx_busy(busy_v[2]), .tx_done(done_v[2]));
  uart_tx #(.CLK_RATE(1000), .BAUD_RATE(100), .DATA_BITS(8), .PARITY(0), .STOP_BITS(2)) dut_n2 (
    .clock(clock), .rst(rst), .tx_start(tx_start_v[3]), .tx_data(tx_data),
    .tx_serial(serial_v[3]), .tx_busy(busy_v[3]), .tx_done(done_v[3]));

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Expected line bits of one frame, index 0 = start bit.
  task automatic build_frame(input logic [7:0] data, input int par, input int stops,
                             output logic [15:0] fr, output int len);
    fr = '1;
    fr[0] = 1'b0;
    for (int i = 0; i < 8; i++) fr[1+i] = data[i];
    len = 9;
    if (par != 0) begin
      fr[len] = (^data) ^ (par == 2);
      len++;
    end
    len = len + stops;
  endtask

  // Drives tx_start for one edge; returns #1 after the accepting edge.
  task automatic send(input int sel, input logic [7:0] data);
    tx_data = data;
    tx_start_v[sel] = 1'b1;
    tick();
    tx_start_v[sel] = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tx_start_v = '0;
    tx_data = '0;
    for (int c = 0; c < 3; c++) begin
      tick();
      checks++;
      if (serial_v !== 4'hF || busy_v !== 4'h0 || done_v !== 4'h0) begin
        errors++;
        $display("FAIL reset_hold cycle %0d: serial=%b busy=%b done=%b required serial=1111 busy=0000 done=0000",
                 c, serial_v, busy_v, done_v);
      end
    end
    rst = 1'b0;
    for (int c = 0; c < 200; c++) begin
      tick();
      checks++;
      if (serial_v !== 4'hF || busy_v !== 4'h0 || done_v !== 4'h0) begin
        errors++;
        $display("FAIL idle_after_reset cycle %0d: serial=%b busy=%b done=%b required serial=1111 busy=0000 done=0000",
                 c, serial_v, busy_v, done_v);
      end
    end
  endtask

  task automatic test_basic_8n1();
    logic [15:0] fr;
    int len;
    logic [9:0] hand;
    hand = 10'b11_0100_1010;  // line order 0,1,0,1,0,0,1,0,1,1 read from bit 0 upward
    build_frame(8'hA5, 0, 1, fr, len);
    send(0, 8'hA5);
    for (int c = 0; c < len * CPB; c++) begin
      checks++;
      if (serial_v[0] !== hand[c / CPB] || busy_v[0] !== 1'b1 || done_v[0] !== 1'b0) begin
        errors++;
        $display("FAIL a5_frame cycle %0d: serial=%b busy=%b done=%b required serial=%b busy=1 done=0",
                 c, serial_v[0], busy_v[0], done_v[0], hand[c / CPB]);
      end
      tick();
    end
    checks++;
    if (done_v[0] !== 1'b1 || busy_v[0] !== 1'b0 || serial_v[0] !== 1'b1 || len != 10) begin
      errors++;
      $display("FAIL a5_done at cycle 100: done=%b busy=%b serial=%b required done=1 busy=0 serial=1",
               done_v[0], busy_v[0], serial_v[0]);
    end
    tick();
    checks++;
    if (done_v[0] !== 1'b0) begin
      errors++;
      $display("FAIL a5_done_width: done=%b one cycle later, required 0", done_v[0]);
    end
  endtask

  task automatic test_ignore_busy();
    logic [15:0] fr;
    int len;
    build_frame(8'h3C, 0, 1, fr, len);
    send(0, 8'h3C);
    for (int c = 0; c < len * CPB; c++) begin
      checks++;
      if (serial_v[0] !== fr[c / CPB] || busy_v[0] !== 1'b1 || done_v[0] !== 1'b0) begin
        errors++;
        $display("FAIL 3c_frame cycle %0d: serial=%b busy=%b done=%b required serial=%b busy=1 done=0",
                 c, serial_v[0], busy_v[0], done_v[0], fr[c / CPB]);
      end
      if (c == 45) begin
        tx_data = 8'hFF;
        tx_start_v[0] = 1'b1;
      end else begin
        tx_start_v[0] = 1'b0;
      end
      tick();
    end
    checks++;
    if (done_v[0] !== 1'b1 || busy_v[0] !== 1'b0) begin
      errors++;
      $display("FAIL 3c_done: done=%b busy=%b required done=1 busy=0", done_v[0], busy_v[0]);
    end
    for (int c = 0; c < 30; c++) begin
      tick();
      checks++;
      if (serial_v[0] !== 1'b1 || busy_v[0] !== 1'b0 || done_v[0] !== 1'b0) begin
        errors++;
        $display("FAIL ignored_start_idle cycle %0d: serial=%b busy=%b done=%b required serial=1 busy=0 done=0",
                 c, serial_v[0], busy_v[0], done_v[0]);
      end
    end
  endtask

  task automatic test_parity_stop();
    logic [15:0] fr;
    int len;
    // Instance 1 even parity, 2 odd parity, 3 two stop bits; all send 0x07.
    for (int sel = 1; sel < 4; sel++) begin
      build_frame(8'h07, (sel == 3) ? 0 : sel, (sel == 3) ? 2 : 1, fr, len);
      send(sel, 8'h07);
      for (int c = 0; c < 110; c++) begin
        checks++;
        if (serial_v[sel] !== fr[c / CPB] || busy_v[sel] !== 1'b1 || done_v[sel] !== 1'b0) begin
          errors++;
          $display("FAIL pfs_frame dut %0d cycle %0d: serial=%b busy=%b done=%b required serial=%b busy=1 done=0",
                   sel, c, serial_v[sel], busy_v[sel], done_v[sel], fr[c / CPB]);
        end
        if (c == 95) begin
          checks++;
          if (serial_v[sel] !== ((sel == 2) ? 1'b0 : 1'b1)) begin
            errors++;
            $display("FAIL bit9 dut %0d: serial=%b required %b", sel, serial_v[sel], (sel == 2) ? 1'b0 : 1'b1);
          end
        end
        tick();
      end
      checks++;
      if (done_v[sel] !== 1'b1 || busy_v[sel] !== 1'b0 || serial_v[sel] !== 1'b1) begin
        errors++;
        $display("FAIL pfs_done dut %0d at cycle 110: done=%b busy=%b serial=%b required done=1 busy=0 serial=1",
                 sel, done_v[sel], busy_v[sel], serial_v[sel]);
      end
      tick();
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] fr;
    int len;
    build_frame(8'h12, 0, 1, fr, len);
    send(0, 8'h12);
    for (int c = 0; c < len * CPB; c++) begin
      checks++;
      if (serial_v[0] !== fr[c / CPB] || busy_v[0] !== 1'b1) begin
        errors++;
        $display("FAIL b2b_first cycle %0d: serial=%b busy=%b required serial=%b busy=1",
                 c, serial_v[0], busy_v[0], fr[c / CPB]);
      end
      tick();
    end
    checks++;
    if (done_v[0] !== 1'b1) begin
      errors++;
      $display("FAIL b2b_first_done: done=%b required 1", done_v[0]);
    end
    build_frame(8'h81, 0, 1, fr, len);
    send(0, 8'h81);
    for (int c = 0; c < len * CPB; c++) begin
      checks++;
      if (serial_v[0] !== fr[c / CPB] || busy_v[0] !== 1'b1 || done_v[0] !== 1'b0) begin
        errors++;
        $display("FAIL b2b_second cycle %0d: serial=%b busy=%b done=%b required serial=%b busy=1 done=0",
                 c, serial_v[0], busy_v[0], done_v[0], fr[c / CPB]);
      end
      tick();
    end
    checks++;
    if (done_v[0] !== 1'b1 || busy_v[0] !== 1'b0) begin
      errors++;
      $display("FAIL b2b_second_done: done=%b busy=%b required done=1 busy=0", done_v[0], busy_v[0]);
    end
    tick();
  endtask

  task automatic test_reset_abort();
    logic [15:0] fr;
    int len;
    build_frame(8'hC3, 0, 1, fr, len);
    send(0, 8'hC3);
    for (int c = 0; c < 45; c++) tick();
    #3;
    rst = 1'b1;
    #1;
    checks++;
    if (serial_v[0] !== 1'b1 || busy_v[0] !== 1'b0 || done_v[0] !== 1'b0) begin
      errors++;
      $display("FAIL async_abort: serial=%b busy=%b done=%b required serial=1 busy=0 done=0",
               serial_v[0], busy_v[0], done_v[0]);
    end
    tick();
    rst = 1'b0;
    for (int c = 0; c < 20; c++) begin
      tick();
      checks++;
      if (serial_v[0] !== 1'b1 || busy_v[0] !== 1'b0 || done_v[0] !== 1'b0) begin
        errors++;
        $display("FAIL post_abort_idle cycle %0d: serial=%b busy=%b done=%b required serial=1 busy=0 done=0",
                 c, serial_v[0], busy_v[0], done_v[0]);
      end
    end
    build_frame(8'h5A, 0, 1, fr, len);
    send(0, 8'h5A);
    for (int c = 0; c < len * CPB; c++) begin
      checks++;
      if (serial_v[0] !== fr[c / CPB] || busy_v[0] !== 1'b1 || done_v[0] !== 1'b0) begin
        errors++;
        $display("FAIL 5a_frame cycle %0d: serial=%b busy=%b done=%b required serial=%b busy=1 done=0",
                 c, serial_v[0], busy_v[0], done_v[0], fr[c / CPB]);
      end
      tick();
    end
    checks++;
    if (done_v[0] !== 1'b1 || busy_v[0] !== 1'b0 || serial_v[0] !== 1'b1) begin
      errors++;
      $display("FAIL 5a_done: done=%b busy=%b serial=%b required done=1 busy=0 serial=1",
               done_v[0], busy_v[0], serial_v[0]);
    end
  endtask

  initial begin
    test_reset();
    test_basic_8n1();
    test_ignore_busy();
    test_parity_stop();
    test_back_to_back();
    test_reset_abort();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
Serial UART transmitter that consumes the one-cycle send pulse produced by the button-debounce stage and shifts out one asynchronous frame on tx_serial. A frame is: start bit, data bits LSB first, optional parity bit, then stop bits. Bit timing comes from an internal baud counter derived from the system clock. The block sits between the debounce/control logic and the board TX pin.

Parameters:
CLK_RATE, 100000000, system clock frequency in Hz
BAUD_RATE, 9600, line rate in bits/s; CLKS_PER_BIT = CLK_RATE/BAUD_RATE (truncating), 10416 at defaults
DATA_BITS, 8, data bits per frame, legal 5..9
PARITY, 0, 0 = none, 1 = even, 2 = odd
STOP_BITS, 1, legal 1 or 2

Ports:
clock  input  1  system clock, rising edge
rst  input  1  reset, asynchronous, active-high
tx_start  input  1  one-cycle request to send, e.g. the debouncer's tx_send
tx_data  input  DATA_BITS  byte to send, sampled only on an accepted tx_start
tx_serial  output  1  serial line, idle high, registered
tx_busy  output  1  high while a frame is in progress
tx_done  output  1  one-cycle pulse when a frame's last stop bit completes

Behaviour:
- Reset (async, any time):
  - tx_serial=1, tx_busy=0, tx_done=0.
  - State IDLE; baud counter and bit index cleared.
  - A frame in progress is aborted; the line returns high immediately.
- States: IDLE -> START -> DATA -> [PARITY if PARITY!=0] -> STOP -> IDLE.
- Accept:
  - tx_start=1 while in IDLE latches tx_data into a shift register.
  - On that edge: tx_serial<=0, tx_busy<=1, state<=START.
  - Latency from the accepting edge to the line falling: that same edge (the output is registered).
- Bit timing:
  - Each bit is held exactly CLKS_PER_BIT cycles.
  - The baud counter runs 0..CLKS_PER_BIT-1 and clears on accept and at every bit boundary, so there is no drift between bits.
- DATA: shift register LSB first. The bit index counts 0..DATA_BITS-1; after the last data bit, go to PARITY or STOP.
- PARITY: XOR of the latched data. Even parity sends the XOR; odd parity sends its inverse.
- STOP: line high for STOP_BITS*CLKS_PER_BIT cycles.
- End of frame: at the edge ending STOP, state<=IDLE, tx_busy<=0, tx_done<=1 for exactly one cycle.
- Frame length: (1+DATA_BITS+(PARITY!=0)+STOP_BITS)*CLKS_PER_BIT cycles from the accepting edge to the edge asserting tx_done.
- tx_start while tx_busy=1: ignored, not queued, no effect on the current frame.
- tx_start in the cycle tx_done=1: accepted (state is IDLE). The next start bit begins on that edge, giving back-to-back frames with no idle gap beyond the stop bits.
- tx_data changes mid-frame: no effect.
- Elaboration-time checks: CLKS_PER_BIT>=2, DATA_BITS in 5..9, PARITY in 0..2, STOP_BITS in 1..2; fail the build otherwise.

Decomposition:
- Package uart_pkg:
  - typedef enum tx_state_t {IDLE, START, DATA, PARITY, STOP}
  - constants PARITY_NONE=0, PARITY_EVEN=1, PARITY_ODD=2
  - function clks_per_bit(clk_rate, baud_rate)
- Sub-module uart_baud_gen:
  - parameter CLKS_PER_BIT; inputs clock, rst, clear, enable; output bit_tick (one cycle at count CLKS_PER_BIT-1).
  - The receiver will reuse it later.
- uart_tx holds the FSM, shift register, bit index and parity logic.

Test Plan (CLK_RATE=1000, BAUD_RATE=100, so CLKS_PER_BIT=10, unless stated):
1. Assert rst for 3 cycles with no start -> tx_serial=1, tx_busy=0, tx_done=0 throughout; line stays high for 200 cycles after release.
2. 8N1, tx_data=0xA5, pulse tx_start -> line 0,1,0,1,0,0,1,0,1,1, each bit 10 cycles; tx_busy high for 100 cycles; tx_done pulses once at cycle 100 after accept.
3. Second tx_start (tx_data=0xFF) at cycle 45 of a 0x3C frame -> only the 0x3C frame is sent; line high after the stop bit; single tx_done.
4. PARITY=1, tx_data=0x07 -> parity bit 1, frame 110 cycles. PARITY=2, same data -> parity bit 0. STOP_BITS=2 -> stop high for 20 cycles, tx_done at cycle 110 (no parity).
5. tx_start held high in the tx_done cycle with tx_data=0x81 -> new start bit begins on that edge, no extra idle; second frame bits correct.
6. rst pulse during data bit 3 -> tx_serial=1 and tx_busy=0 asynchronously, no tx_done; a subsequent tx_start with 0x5A produces a clean full frame.
